regfile_wb_arbiter: RTL and testbench

Write-back arbiter for the MIPS register file's single write port. Up to `NUM_REQ` producers (ALU, load unit, mult/div unit) present destination/data pairs with a valid/ready handshake. A round-robin arbiter picks one per cycle and registers it into an output stage that drives the register file's `reg_write`, `rd` and `write_data` inputs. The block also exports a pending-write mask for the hazard/stall logic.

---
 rtl/mips_pkg.sv | 7 +
 rtl/rr_arbiter.sv | 40 ++++
 rtl/regfile_wb_arbiter.sv | 85 ++++++++
 tb/tb_regfile_wb_arbiter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS register-file constants used by the write-back path.
package mips_pkg;
    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;
    localparam int REG_ZERO = 0;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from ptr upward, ptr moves past the winner.
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    input  logic         en,
    output logic [N-1:0] gnt
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_sel;
    logic          w_found;
    int            w_j;

    always_comb begin
        gnt     = '0;
        w_sel   = r_ptr;
        w_found = 1'b0;
        w_j     = 0;
        for (int k = 0; k < N; k++) begin
            w_j = int'(r_ptr) + k;
            if (w_j >= N) w_j = w_j - N;
            if (!w_found && en && req[w_j]) begin
                w_found  = 1'b1;
                w_sel    = PW'(w_j);
                gnt[w_j] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_ptr <= '0;
        else if (w_found)
            r_ptr <= (w_sel == PW'(N - 1)) ? '0 : w_sel + 1'b1;
    end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the register file's single write port: round-robin grant,
// one registered output stage, rd=0 squash and a pending-write mask for hazard logic.
module regfile_wb_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0] req_rd,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic                      hold,
    output logic                      wb_reg_write,
    output logic [ADDR_W-1:0]         wb_rd,
    output logic [DATA_W-1:0]         wb_write_data,
    output logic [31:0]               pending_mask
);
    import mips_pkg::*;

    logic [NUM_REQ-1:0] w_gnt;
    logic               w_en;
    logic               w_xfer;
    logic [ADDR_W-1:0]  w_rd;
    logic [DATA_W-1:0]  w_data;
    logic               r_we;
    logic [ADDR_W-1:0]  r_rd;
    logic [DATA_W-1:0]  r_data;

    // Gating with reset keeps req_ready low for the whole reset window.
    assign w_en = ~hold & ~reset;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .clk   (clk),
        .reset (reset),
        .req   (req_valid),
        .en    (w_en),
        .gnt   (w_gnt)
    );

    assign req_ready = w_gnt;
    assign w_xfer    = |w_gnt;

    always_comb begin
        w_rd   = '0;
        w_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt[i]) begin
                w_rd   = req_rd[i*ADDR_W +: ADDR_W];
                w_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // rd=0 is consumed like any other request but never raises the write strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_we   <= 1'b0;
            r_rd   <= '0;
            r_data <= '0;
        end else begin
            r_we <= w_xfer && (w_rd != ADDR_W'(REG_ZERO));
            if (w_xfer) begin
                r_rd   <= w_rd;
                r_data <= w_data;
            end
        end
    end

    assign wb_reg_write  = r_we;
    assign wb_rd         = r_rd;
    assign wb_write_data = r_data;

    always_comb begin
        pending_mask = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i])
                pending_mask[req_rd[i*ADDR_W +: ADDR_W]] = 1'b1;
        end
        if (r_we)
            pending_mask[r_rd] = 1'b1;
        pending_mask[REG_ZERO] = 1'b0;
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed vector table, corner sequences, random vs model.
module tb_regfile_wb_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  req_valid = '0;
    logic [2:0]  req_ready;
    logic [14:0] req_rd = '0;
    logic [95:0] req_data = '0;
    logic        hold = 1'b0;
    logic        wb_reg_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_write_data;
    logic [31:0] pending_mask;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] rf [32];

    regfile_wb_arbiter #(.NUM_REQ(3), .ADDR_W(5), .DATA_W(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_rd        (req_rd),
        .req_data      (req_data),
        .hold          (hold),
        .wb_reg_write  (wb_reg_write),
        .wb_rd         (wb_rd),
        .wb_write_data (wb_write_data),
        .pending_mask  (pending_mask)
    );

    always #5 clk = ~clk;

    // Simple register file sitting on the write port (does not special-case r0).
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 32; k++) rf[k] <= '0;
        end else if (wb_reg_write) begin
            rf[wb_rd] <= wb_write_data;
        end
    end

    typedef struct {
        logic        h;
        logic [2:0]  v;
        logic [14:0] rd;
        logic [95:0] data;
        logic [2:0]  rdy;
        logic        we;
        logic [4:0]  erd;
        logic [31:0] ed;
    } vec_t;

    vec_t tbl [14];

    function automatic vec_t mk(input logic h, input logic [2:0] v,
                                input logic [4:0] r2, input logic [4:0] r1, input logic [4:0] r0,
                                input logic [31:0] d2, input logic [31:0] d1, input logic [31:0] d0,
                                input logic [2:0] rdy, input logic we, input logic [4:0] erd,
                                input logic [31:0] ed);
        vec_t t;
        t.h = h; t.v = v; t.rd = {r2, r1, r0}; t.data = {d2, d1, d0};
        t.rdy = rdy; t.we = we; t.erd = erd; t.ed = ed;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        req_valid = '0;
        hold      = 1'b0;
        reset     = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Random-section requester state and reference model
    logic [2:0]  v;
    logic [4:0]  rrd  [3];
    logic [31:0] rdat [3];
    int          mptr;
    logic        mwe;
    logic [4:0]  mrd;
    logic [31:0] mdata;

    initial begin
        int g;
        int j;
        int gk;
        logic        h;
        logic [2:0]  exp_rdy;
        logic [31:0] exp_pm;

        tbl[0]  = mk(0, 3'b111, 3, 2, 1, 32'h33, 32'h22, 32'h11, 3'b001, 0, 0, 32'h0);
        tbl[1]  = mk(0, 3'b110, 3, 2, 1, 32'h33, 32'h22, 32'h11, 3'b010, 1, 1, 32'h11);
        tbl[2]  = mk(0, 3'b100, 3, 2, 1, 32'h33, 32'h22, 32'h11, 3'b100, 1, 2, 32'h22);
        tbl[3]  = mk(0, 3'b000, 3, 2, 1, 32'h33, 32'h22, 32'h11, 3'b000, 1, 3, 32'h33);
        tbl[4]  = mk(0, 3'b010, 3, 7, 1, 32'h33, 32'hDEADBEEF, 32'h11, 3'b010, 0, 3, 32'h33);
        tbl[5]  = mk(0, 3'b000, 3, 7, 1, 32'h33, 32'hDEADBEEF, 32'h11, 3'b000, 1, 7, 32'hDEADBEEF);
        tbl[6]  = mk(0, 3'b100, 0, 7, 1, 32'hFFFFFFFF, 32'hDEADBEEF, 32'h11, 3'b100, 0, 7, 32'hDEADBEEF);
        tbl[7]  = mk(0, 3'b000, 0, 7, 1, 32'hFFFFFFFF, 32'hDEADBEEF, 32'h11, 3'b000, 0, 0, 32'hFFFFFFFF);
        tbl[8]  = mk(0, 3'b111, 3, 2, 1, 32'h33, 32'h22, 32'h11, 3'b001, 0, 0, 32'hFFFFFFFF);
        tbl[9]  = mk(0, 3'b000, 3, 2, 1, 32'h33, 32'h22, 32'h11, 3'b000, 1, 1, 32'h11);
        tbl[10] = mk(1, 3'b011, 3, 2, 1, 32'h33, 32'h22, 32'h11, 3'b000, 0, 1, 32'h11);
        tbl[11] = mk(0, 3'b011, 3, 2, 1, 32'h33, 32'h22, 32'h11, 3'b010, 0, 1, 32'h11);
        tbl[12] = mk(0, 3'b001, 3, 2, 1, 32'h33, 32'h22, 32'h11, 3'b001, 1, 2, 32'h22);
        tbl[13] = mk(0, 3'b000, 3, 2, 1, 32'h33, 32'h22, 32'h11, 3'b000, 1, 1, 32'h11);

        // Reset state
        req_valid = 3'b111;
        #2;
        chk("rst_ready", req_ready, 3'b000);
        chk("rst_we", wb_reg_write, 1'b0);
        chk("rst_rd", wb_rd, 5'd0);
        chk("rst_data", wb_write_data, 32'h0);
        do_reset();

        // Directed table: contention, single request, rd=0, hold
        for (int i = 0; i < 14; i++) begin
            hold = tbl[i].h; req_valid = tbl[i].v; req_rd = tbl[i].rd; req_data = tbl[i].data;
            @(negedge clk);
            chk($sformatf("tbl%0d_ready", i), req_ready, tbl[i].rdy);
            chk($sformatf("tbl%0d_we", i), wb_reg_write, tbl[i].we);
            chk($sformatf("tbl%0d_rd", i), wb_rd, tbl[i].erd);
            chk($sformatf("tbl%0d_data", i), wb_write_data, tbl[i].ed);
            chk($sformatf("tbl%0d_pm0", i), pending_mask[0], 1'b0);
            @(posedge clk); #1;
        end
        chk("rf_r7", rf[7], 32'hDEADBEEF);
        chk("rf_r0", rf[0], 32'h0);
        chk("rf_r1", rf[1], 32'h11);
        chk("rf_r2", rf[2], 32'h22);
        chk("rf_r3", rf[3], 32'h33);

        // Reset mid-stream with r5 staged
        do_reset();
        req_valid = 3'b010; req_rd = {5'd3, 5'd5, 5'd1}; req_data = {32'h33, 32'h55, 32'h11};
        @(posedge clk); #1;
        chk("mid_staged_we", wb_reg_write, 1'b1);
        chk("mid_staged_rd", wb_rd, 5'd5);
        req_valid = 3'b111; req_rd = {5'd3, 5'd2, 5'd1};
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_we", wb_reg_write, 1'b0);
        chk("mid_rst_rd", wb_rd, 5'd0);
        chk("mid_rst_ready", req_ready, 3'b000);
        @(posedge clk); #1 reset = 1'b0;
        #1;
        chk("mid_post_ready", req_ready, 3'b001);

        // Hold for 3 cycles with r4 pending, then hold again while the write is staged
        do_reset();
        req_valid = 3'b001; req_rd = {5'd0, 5'd0, 5'd4}; req_data = {32'h0, 32'h0, 32'h44};
        hold = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("hold%0d_ready", c), req_ready, 3'b000);
            chk($sformatf("hold%0d_pm4", c), pending_mask[4], 1'b1);
            @(posedge clk); #1;
        end
        hold = 1'b0;
        @(negedge clk);
        chk("hold_release_ready", req_ready, 3'b001);
        @(posedge clk); #1;
        req_valid = 3'b000; hold = 1'b1;
        @(negedge clk);
        chk("hold_staged_we", wb_reg_write, 1'b1);
        chk("hold_staged_rd", wb_rd, 5'd4);
        chk("hold_staged_pm4", pending_mask[4], 1'b1);
        @(posedge clk); #1;
        hold = 1'b0;
        @(negedge clk);
        chk("hold_done_pm4", pending_mask[4], 1'b0);
        chk("hold_done_we", wb_reg_write, 1'b0);

        // Fairness: requester 0 always valid, requester 2 joins at cycle N
        do_reset();
        req_valid = 3'b001; req_rd = {5'd9, 5'd0, 5'd8}; req_data = {32'h99, 32'h0, 32'h88};
        @(posedge clk); #1;
        req_valid = 3'b101;
        gk = -1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (gk < 0 && req_ready[2]) gk = k;
            @(posedge clk); #1;
            if (gk >= 0) req_valid[2] = 1'b0;
        end
        chk("fair_req2_granted", (gk >= 0 && gk <= 2), 1'b1);

        // Random traffic against the reference model
        do_reset();
        v = '0; mptr = 0; mwe = 1'b0; mrd = '0; mdata = '0;
        for (int k = 0; k < 3; k++) begin rrd[k] = '0; rdat[k] = '0; end
        for (int n = 0; n < 300; n++) begin
            for (int k = 0; k < 3; k++) begin
                if (!v[k] && $urandom_range(0, 1) == 1) begin
                    v[k] = 1'b1;
                    rrd[k] = 5'($urandom_range(0, 7));
                    rdat[k] = $urandom;
                end
            end
            h = ($urandom_range(0, 4) == 0);
            hold = h; req_valid = v;
            req_rd = {rrd[2], rrd[1], rrd[0]};
            req_data = {rdat[2], rdat[1], rdat[0]};
            g = -1;
            if (!h) begin
                for (int k = 0; k < 3; k++) begin
                    j = (mptr + k) % 3;
                    if (g < 0 && v[j]) g = j;
                end
            end
            exp_rdy = (g < 0) ? 3'b000 : 3'(1 << g);
            exp_pm = '0;
            for (int k = 0; k < 3; k++) if (v[k]) exp_pm[rrd[k]] = 1'b1;
            if (mwe) exp_pm[mrd] = 1'b1;
            exp_pm[0] = 1'b0;
            @(negedge clk);
            chk("rnd_ready", req_ready, exp_rdy);
            chk("rnd_pm", pending_mask, exp_pm);
            chk("rnd_we", wb_reg_write, mwe);
            chk("rnd_rd", wb_rd, mrd);
            chk("rnd_data", wb_write_data, mdata);
            @(posedge clk); #1;
            if (g >= 0) begin
                mwe = (rrd[g] != 5'd0);
                mrd = rrd[g];
                mdata = rdat[g];
                mptr = (g + 1) % 3;
                v[g] = 1'b0;
            end else begin
                mwe = 1'b0;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
